// File: rtl/fetch_buffer_pkg.sv
// Shared RV32I constants plus the fetch-buffer queue entry layout and address helper.
package rv32i_pkg;
  localparam int          XLEN    = 32;
  localparam int          INST_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0013;
endpackage

package fetch_buffer_pkg;
  import rv32i_pkg::*;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fb_entry_t;

  localparam int ENTRY_W = $bits(fb_entry_t);

  // Fetches are always word sized; low address bits are dropped, not trapped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    word_align = {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-stage bundle: PC loop, instruction-memory port and decode handshake.
interface fetch_buffer_if import rv32i_pkg::*; #(parameter int DEPTH = 4);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              start;
  logic [XLEN-1:0]   pc_in;
  logic              flush;
  logic [XLEN-1:0]   pc_next;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_en;
  logic [INST_W-1:0] imem_rdata;
  logic              dec_valid;
  logic              dec_ready;
  logic [INST_W-1:0] dec_inst;
  logic [XLEN-1:0]   dec_pc;
  logic [CNT_W-1:0]  count;

  modport master (
    output start, pc_in, flush, imem_rdata, dec_ready,
    input  pc_next, imem_addr, imem_en, dec_valid, dec_inst, dec_pc, count
  );

  modport slave (
    input  start, pc_in, flush, imem_rdata, dec_ready,
    output pc_next, imem_addr, imem_en, dec_valid, dec_inst, dec_pc, count
  );
endinterface

// File: rtl/fetch_buffer_chk.sv
// Guards the credit scheme: the queue must never see a push while already full.
module fetch_buffer_chk #(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             reset,
  input logic             push,
  input logic             flush,
  input logic [CNT_W-1:0] count
);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    (push && !flush) |-> (count != CNT_FULL));
endmodule

// File: rtl/sync_fifo.sv
// Circular FIFO with synchronous flush; head data is read straight from storage.
module sync_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             empty_s;
  logic             full_s;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign empty_s   = (count_r == {CNT_W{1'b0}});
  assign full_s    = (count_r == CNT_FULL);
  assign pop_ok_s  = pop & ~empty_s & ~flush;
  assign push_ok_s = push & ~flush & (~full_s | pop_ok_s);

  // Storage write; entries are only meaningful between head and tail, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[tail_r] <= push_data;
    end
  end

  // Pointer and occupancy update; power-of-two DEPTH makes pointer wrap implicit.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[head_r];
  assign valid     = ~empty_s;
  assign count     = count_r;
endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: credit-based issue to a 1-cycle memory, results queued for decode.
module fetch_buffer import rv32i_pkg::*, fetch_buffer_pkg::*; #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  fetch_buffer_if.slave bus
);
  localparam int               CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DEPTH);

  logic             issue_s;
  logic             fifo_flush_s;
  logic             push_s;
  logic             pop_s;
  logic             head_valid_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W-1:0] credit_s;
  logic [XLEN-1:0]  fetch_addr_s;
  logic             inflight_v_r;
  logic [XLEN-1:0]  inflight_pc_r;
  fb_entry_t        push_entry_s;
  fb_entry_t        head_entry_s;

  // An outstanding read already owns a queue slot, so it counts against the credit.
  assign fetch_addr_s = word_align(bus.pc_in);
  assign credit_s     = count_s + CNT_W'(inflight_v_r);
  assign issue_s      = bus.start & ~bus.flush & ~reset & (credit_s < CREDIT_MAX);

  assign bus.imem_en   = issue_s;
  assign bus.imem_addr = fetch_addr_s;
  assign bus.pc_next   = issue_s ? (bus.pc_in + PC_STEP) : bus.pc_in;

  // Tracks the single read whose data returns next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_v_r  <= 1'b0;
      inflight_pc_r <= {XLEN{1'b0}};
    end else if (issue_s) begin
      inflight_v_r  <= 1'b1;
      inflight_pc_r <= fetch_addr_s;
    end else begin
      inflight_v_r  <= 1'b0;
    end
  end

  assign fifo_flush_s = bus.flush | ~bus.start;
  assign push_s       = inflight_v_r;
  assign push_entry_s = '{inst: bus.imem_rdata, pc: inflight_pc_r};
  assign pop_s        = head_valid_s & bus.dec_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush_s),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .head_data (head_entry_s),
    .valid     (head_valid_s),
    .count     (count_s)
  );

  fetch_buffer_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .flush (fifo_flush_s),
    .count (count_s)
  );

  // Empty queue presents zeros rather than stale storage.
  assign bus.dec_valid = head_valid_s;
  assign bus.dec_inst  = head_valid_s ? head_entry_s.inst : {INST_W{1'b0}};
  assign bus.dec_pc    = head_valid_s ? head_entry_s.pc : {XLEN{1'b0}};
  assign bus.count     = count_s;
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: PC register and 1-cycle memory modelled around the DUT.
module tb_fetch_buffer;
  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] mem_key;
  int          n_cmp;
  int          n_err;

  fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register fed by pc_next (or a redirect) and memory returning addr^key one cycle later
  always @(posedge clk) begin
    bus.pc_in      <= redirect_en ? redirect_pc : bus.pc_next;
    bus.imem_rdata <= bus.imem_en ? (bus.imem_addr ^ mem_key) : 32'hDEAD_BEEF;
  end

  task automatic drive(input logic s, input logic f, input logic r);
    @(negedge clk);
    bus.start     = s;
    bus.flush     = f;
    bus.dec_ready = r;
    redirect_en   = 1'b0;
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_en = 1'b1;
    redirect_pc = pc;
  endtask

  task automatic park(input logic [31:0] pc);
    drive(1'b0, 1'b0, 1'b0);
    redirect(pc);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 1'b1);
      redirect(32'h0);
      n_cmp++; if (bus.imem_en !== 1'b0) begin n_err++; $display("FAIL rst_imem_en k=%0d: got %b want 0", k, bus.imem_en); end
      n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL rst_dec_valid k=%0d: got %b want 0", k, bus.dec_valid); end
      n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL rst_count k=%0d: got %0d want 0", k, bus.count); end
    end
    n_cmp++; if (bus.pc_next !== 32'h0) begin n_err++; $display("FAIL rst_pc_next: got %h want 0", bus.pc_next); end
    reset = 1'b0;
    park(32'h0);
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL post_rst_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.imem_en !== 1'b0) begin n_err++; $display("FAIL post_rst_imem_en: got %b want 0", bus.imem_en); end
  endtask

  task automatic test_streaming();
    logic [31:0] exp_pc;
    mem_key = 32'h0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 1'b1);
      exp_pc = 32'(k) * 32'd4;
      n_cmp++; if (bus.imem_en !== 1'b1) begin n_err++; $display("FAIL str_imem_en k=%0d: got %b want 1", k, bus.imem_en); end
      n_cmp++; if (bus.imem_addr !== exp_pc) begin n_err++; $display("FAIL str_imem_addr k=%0d: got %h want %h", k, bus.imem_addr, exp_pc); end
      n_cmp++; if (bus.pc_next !== exp_pc + 32'd4) begin n_err++; $display("FAIL str_pc_next k=%0d: got %h want %h", k, bus.pc_next, exp_pc + 32'd4); end
      if (k < 2) begin
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL str_early_valid k=%0d: got %b want 0", k, bus.dec_valid); end
      end else begin
        exp_pc = 32'(k - 2) * 32'd4;
        n_cmp++; if (bus.dec_valid !== 1'b1) begin n_err++; $display("FAIL str_dec_valid k=%0d: got %b want 1", k, bus.dec_valid); end
        n_cmp++; if (bus.dec_pc !== exp_pc) begin n_err++; $display("FAIL str_dec_pc k=%0d: got %h want %h", k, bus.dec_pc, exp_pc); end
        n_cmp++; if (bus.dec_inst !== exp_pc) begin n_err++; $display("FAIL str_dec_inst k=%0d: got %h want %h", k, bus.dec_inst, exp_pc); end
        n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL str_count k=%0d: got %0d want 1", k, bus.count); end
      end
    end
    park(32'h0);
  endtask

  task automatic test_backpressure();
    int          exp_cnt [12];
    logic        exp_en  [12];
    logic [31:0] issue_pc;
    logic [31:0] exp_pc;
    exp_cnt  = '{0, 0, 1, 2, 3, 4, 4, 3, 2, 2, 2, 2};
    exp_en   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    mem_key  = 32'h1300_0000;
    issue_pc = 32'h0;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 1'b0, (k >= 6) ? 1'b1 : 1'b0);
      n_cmp++; if (bus.count !== 3'(exp_cnt[k])) begin n_err++; $display("FAIL bp_count k=%0d: got %0d want %0d", k, bus.count, exp_cnt[k]); end
      n_cmp++; if (bus.imem_en !== exp_en[k]) begin n_err++; $display("FAIL bp_imem_en k=%0d: got %b want %b", k, bus.imem_en, exp_en[k]); end
      n_cmp++; if (bus.dec_valid !== (exp_cnt[k] != 0)) begin n_err++; $display("FAIL bp_dec_valid k=%0d: got %b", k, bus.dec_valid); end
      if (exp_en[k]) begin
        n_cmp++; if (bus.imem_addr !== issue_pc) begin n_err++; $display("FAIL bp_imem_addr k=%0d: got %h want %h", k, bus.imem_addr, issue_pc); end
        issue_pc = issue_pc + 32'd4;
      end else begin
        n_cmp++; if (bus.pc_next !== issue_pc) begin n_err++; $display("FAIL bp_pc_hold k=%0d: got %h want %h", k, bus.pc_next, issue_pc); end
      end
      if (k >= 6) begin
        exp_pc = 32'(k - 6) * 32'd4;
        n_cmp++; if (bus.dec_pc !== exp_pc) begin n_err++; $display("FAIL bp_dec_pc k=%0d: got %h want %h", k, bus.dec_pc, exp_pc); end
        n_cmp++; if (bus.dec_inst !== (exp_pc ^ mem_key)) begin n_err++; $display("FAIL bp_dec_inst k=%0d: got %h want %h", k, bus.dec_inst, exp_pc ^ mem_key); end
      end
    end
    park(32'h0);
  endtask

  task automatic test_flush();
    mem_key = 32'h1300_0000;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    redirect(32'h0000_0100);
    n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL fl_pre_count: got %0d want 2", bus.count); end
    n_cmp++; if (bus.imem_en !== 1'b0) begin n_err++; $display("FAIL fl_imem_en: got %b want 0", bus.imem_en); end
    n_cmp++; if (bus.pc_next !== 32'hC) begin n_err++; $display("FAIL fl_pc_next: got %h want 0000000c", bus.pc_next); end
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL fl_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL fl_dec_valid: got %b want 0", bus.dec_valid); end
    n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL fl_redirect_addr: got %h want 00000100", bus.imem_addr); end
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL fl_late_drop: got %0d want 0", bus.count); end
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus.dec_pc !== 32'h100) begin n_err++; $display("FAIL fl_first_pc: got %h want 00000100", bus.dec_pc); end
    n_cmp++; if (bus.dec_inst !== (32'h100 ^ mem_key)) begin n_err++; $display("FAIL fl_first_inst: got %h want %h", bus.dec_inst, 32'h100 ^ mem_key); end
    park(32'h0);
  endtask

  task automatic test_push_pop_wrap();
    logic [31:0] exp_pc;
    mem_key = 32'h0055_0000;
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL pp_fill_count: got %0d want 1", bus.count); end
    for (int k = 3; k < 16; k++) begin
      drive(1'b1, 1'b0, 1'b1);
      exp_pc = 32'(k - 3) * 32'd4;
      n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL pp_count k=%0d: got %0d want 2", k, bus.count); end
      n_cmp++; if (bus.dec_pc !== exp_pc) begin n_err++; $display("FAIL pp_dec_pc k=%0d: got %h want %h", k, bus.dec_pc, exp_pc); end
      n_cmp++; if (bus.dec_inst !== (exp_pc ^ mem_key)) begin n_err++; $display("FAIL pp_dec_inst k=%0d: got %h want %h", k, bus.dec_inst, exp_pc ^ mem_key); end
    end
  endtask

  task automatic test_start_drop_reset();
    drive(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.imem_en !== 1'b0) begin n_err++; $display("FAIL sd_imem_en: got %b want 0", bus.imem_en); end
    n_cmp++; if (bus.pc_next !== 32'h40) begin n_err++; $display("FAIL sd_pc_hold: got %h want 00000040", bus.pc_next); end
    drive(1'b0, 1'b0, 1'b1);
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL sd_count: got %0d want 0", bus.count); end
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL sd_dec_valid: got %b want 0", bus.dec_valid); end
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.imem_addr !== 32'h40 || bus.imem_en !== 1'b1) begin n_err++; $display("FAIL sd_restart: got en=%b addr=%h want en=1 addr=00000040", bus.imem_en, bus.imem_addr); end
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.imem_en !== 1'b0) begin n_err++; $display("FAIL mr_imem_en: got %b want 0", bus.imem_en); end
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL mr_no_push: got %0d want 0", bus.count); end
    n_cmp++; if (bus.dec_valid !== 1'b0) begin n_err++; $display("FAIL mr_dec_valid: got %b want 0", bus.dec_valid); end
    n_cmp++; if (bus.imem_addr !== 32'h44) begin n_err++; $display("FAIL mr_pc_held: got %h want 00000044", bus.imem_addr); end
    park(32'hFFFF_FFFC);
  endtask

  task automatic test_wrap_align();
    mem_key = 32'h0A00_0000;
    drive(1'b1, 1'b0, 1'b0);
    n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_addr: got %h want fffffffc", bus.imem_addr); end
    n_cmp++; if (bus.pc_next !== 32'h0) begin n_err++; $display("FAIL wr_pc_next: got %h want 00000000", bus.pc_next); end
    park(32'h0000_0103);
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL al_addr: got %h want 00000100", bus.imem_addr); end
    n_cmp++; if (bus.pc_next !== 32'h107) begin n_err++; $display("FAIL al_pc_next: got %h want 00000107", bus.pc_next); end
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1);
    n_cmp++; if (bus.dec_pc !== 32'h100) begin n_err++; $display("FAIL al_dec_pc: got %h want 00000100", bus.dec_pc); end
    n_cmp++; if (bus.dec_inst !== (32'h100 ^ mem_key)) begin n_err++; $display("FAIL al_dec_inst: got %h want %h", bus.dec_inst, 32'h100 ^ mem_key); end
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    reset         = 1'b1;
    redirect_en   = 1'b1;
    redirect_pc   = 32'h0;
    mem_key       = 32'h0;
    bus.start     = 1'b0;
    bus.flush     = 1'b0;
    bus.dec_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_push_pop_wrap();
    test_start_drop_reset();
    test_wrap_align();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of instruction-queue entries; legal values 2, 4 or 8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  run enable; low is treated as a flush every cycle.
REQ-005 pc_in  input  32  current fetch address, taken from the PC register output.
REQ-006 flush  input  1  redirect (ecall/branch); discards all buffered and in-flight work.
REQ-007 pc_next  output  32  next-PC value, fed to the PC register input.
REQ-008 imem_addr  output  32  instruction-memory byte address.
REQ-009 imem_en  output  1  instruction-memory read enable.
REQ-010 imem_rdata  input  32  instruction word, valid exactly one cycle after its imem_en cycle.
REQ-011 dec_valid  output  1  queue head holds a valid instruction for decode.
REQ-012 dec_ready  input  1  decode accepts the head this cycle.
REQ-013 dec_inst  output  32  instruction word at the queue head.
REQ-014 dec_pc  output  32  byte address of dec_inst.
REQ-015 count  output  clog2(DEPTH)+1  number of occupied queue entries.

Function
REQ-016 issue = start & ~flush & ~reset & (count + inflight_v < DEPTH); the credit check SHALL be evaluated on current-cycle register values.
REQ-017 imem_en SHALL equal issue (combinational), and imem_addr SHALL be {pc_in[31:2],2'b00}.
REQ-018 pc_next SHALL be pc_in + 4 (mod 2^32) when issue is 1, and pc_in otherwise (PC holds on a stall).
REQ-019 On issue, the inflight register SHALL capture inflight_v=1 and inflight_pc=imem_addr; otherwise inflight_v SHALL be 0 next cycle.
REQ-020 When inflight_v is 1 and there is no flush, {imem_rdata, inflight_pc} SHALL be pushed at the tail at the end of that cycle.
REQ-021 Pop when dec_valid & dec_ready; dec_inst/dec_pc SHALL be driven from registered queue storage, never bypassed from imem_rdata.
REQ-022 Latency: an issue in cycle N SHALL produce dec_valid in cycle N+2, given an empty queue and no flush.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged, and both operations SHALL take effect.
REQ-024 Full: credits guarantee no push while count==DEPTH; an overflow is a design error and SHALL be asserted against.
REQ-025 Empty: dec_valid SHALL be 0, and dec_ready SHALL then be ignored.
REQ-026 Head/tail pointers SHALL wrap modulo DEPTH; order SHALL be strict FIFO.
REQ-027 flush or ~start SHALL, at the next edge, set count=0, head=tail=0 and inflight_v=0; the same-cycle push and pop SHALL be suppressed.
REQ-028 flush has priority over issue, push and pop; while it is asserted, pc_next=pc_in and imem_en=0.
REQ-029 Instructions SHALL NOT be decoded or inspected; misaligned pc_in is silently word-aligned.

Reset
REQ-030 reset SHALL clear count, head, tail, inflight_v and inflight_pc to 0, giving dec_valid=0 and imem_en=0 during and after the reset cycle.
REQ-031 Queue data storage SHALL need no reset.
REQ-032 Reset mid-operation SHALL discard in-flight imem_rdata that returns the following cycle.

Structure
REQ-033 The shared package rv32i_pkg SHALL hold XLEN=32, INST_W=32, PC_STEP=4 and the NOP encoding 32'h00000013.
REQ-034 The queue SHALL be one sub-module, sync_fifo (parameters WIDTH=64, DEPTH), with a synchronous flush port.
REQ-035 The target size is about 150-300 RTL lines; there are no latches and a single clock domain.

Verification
REQ-036 Streaming: reset, then start=1, pc_in follows pc_next from 0, dec_ready=1, imem returns word=addr -> dec_pc/dec_inst = 0,4,8,... one per cycle starting at cycle 2.
REQ-037 Backpressure: dec_ready=0 with DEPTH=4 -> count saturates at 4, imem_en=0, pc_next holds at 0x10; releasing dec_ready resumes in order 0x0..0xC then 0x10.
REQ-038 Flush: flush at pc 0x8 with 2 entries plus 1 in flight -> next cycle count=0 and dec_valid=0; the late imem_rdata is dropped; after redirect to 0x100 the first dec_pc=0x100.
REQ-039 Simultaneous push/pop at count=2 -> count stays 2, and pointer wrap verified over 3×DEPTH transfers.
REQ-040 start deasserted mid-stream -> behaves as flush; reset asserted with inflight_v=1 -> no push next cycle and all outputs 0.
REQ-041 Wrap: pc_in=0xFFFFFFFC issue -> pc_next=0x00000000.
